// File: rtl/ovw_fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ovw_fifo_rr_arbiter
// Description : NUM_REQ writers share one overwrite-on-full buffer through a
//               round-robin arbiter. The buffer keeps the newest DEPTH
//               entries, each tagged with the ID of the requester that wrote
//               it. A write into a full buffer with no pop in the same cycle
//               discards the oldest entry and bumps a saturating drop counter.
//
// Ports       : clk       clock
//               resetn    synchronous active-low reset
//               req       per-requester write request
//               din       packed write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//               gnt       one-hot grant, combinational from req
//               rd        pop the oldest entry (ignored when empty)
//               dout      data of the oldest entry
//               dout_src  source ID of the oldest entry
//               full      buffer holds DEPTH entries
//               empty     buffer holds no entries
//               count     current occupancy
//               drop_cnt  number of overwritten entries, saturating
//
// Revision    : 1.0 - initial release
// ============================================================================
module ovw_fifo_rr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int DEPTH      = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] din,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          rd,
    output logic [DATA_WIDTH-1:0]         dout,
    output logic [$clog2(NUM_REQ)-1:0]    dout_src,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(DEPTH):0]        count,
    output logic [CNT_WIDTH-1:0]          drop_cnt
);

    localparam int SRC_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [SRC_W-1:0]      r_tag [DEPTH];
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_full;
    logic                  r_empty;
    logic [CNT_WIDTH-1:0]  r_drop_cnt;
    logic [SRC_W-1:0]      r_prio;

    // ------------------------------------------------------------------
    // Round-robin arbitration: scan upward from r_prio with wrap-around,
    // the first asserted request wins.
    // ------------------------------------------------------------------
    logic             w_gnt_valid;
    logic [SRC_W-1:0] w_gnt_idx;
    logic [SRC_W-1:0] w_scan_idx;

    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        w_scan_idx  = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_scan_idx = SRC_W'((int'(r_prio) + off) % NUM_REQ);
            if (!w_gnt_valid && req[w_scan_idx]) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = w_scan_idx;
            end
        end
    end

    // A grant is never refused by the buffer, so a grant is a write.
    // Nothing is granted while reset is held.
    logic w_wr;
    assign w_wr = w_gnt_valid && resetn;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
            assign gnt[gi] = w_wr && (w_gnt_idx == SRC_W'(gi));
        end
    endgenerate

    logic [DATA_WIDTH-1:0] w_wr_data;
    assign w_wr_data = din[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];

    // ------------------------------------------------------------------
    // Occupancy bookkeeping
    // ------------------------------------------------------------------
    logic             w_pop;
    logic             w_drop;
    logic             w_adv_rd;
    logic [CNT_W:0]   w_count_sum;
    logic [CNT_W-1:0] w_count_next;

    assign w_pop  = rd && !r_empty;
    // Overwrite: the write needs the oldest slot and no pop freed it.
    assign w_drop = w_wr && r_full && !w_pop;
    // The read pointer moves on a real pop and also when an overwrite
    // evicts the oldest entry.
    assign w_adv_rd = w_pop || w_drop;

    always_comb begin
        w_count_sum  = {1'b0, r_count} + (CNT_W+1)'(w_wr) - (CNT_W+1)'(w_pop);
        w_count_next = w_count_sum[CNT_W-1:0];
        if (w_count_sum > (CNT_W+1)'(DEPTH)) begin
            w_count_next = CNT_W'(DEPTH);
        end
    end

    // ------------------------------------------------------------------
    // Sequential update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
                r_tag[i] <= '0;
            end
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_drop_cnt <= '0;
            r_prio     <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_wr_data;
                r_tag[r_wr_ptr] <= w_gnt_idx;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
                r_prio          <= (w_gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0
                                                                      : w_gnt_idx + SRC_W'(1);
            end
            if (w_adv_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_drop && (r_drop_cnt != {CNT_WIDTH{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_W'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign dout     = r_mem[r_rd_ptr];
    assign dout_src = r_tag[r_rd_ptr];
    assign full     = r_full;
    assign empty    = r_empty;
    assign count    = r_count;
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire
